// File: rtl/mode2_sub_pipe.sv
// NUM-lane saturating add/subtract against a registered broadcast operand B,
// two-stage valid/ready pipeline with output transfer statistics.
module mode2_sub_pipe #(
   parameter int NUM    = 4,
   parameter int DWIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    b_load,
   input  logic [DWIDTH-1:0]       b_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_op,
   input  logic [NUM*DWIDTH-1:0]   a_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NUM*DWIDTH-1:0]   out_data,
   output logic [NUM-1:0]          out_sat,
   output logic                    sticky_sat,
   output logic [15:0]             beat_count,
   input  logic                    clear_stats
);

   localparam int LW = NUM * DWIDTH;

   // Returns {sat, result}; overflow shows up as disagreement of the two top bits.
   function automatic logic [DWIDTH:0] sat_addsub(input logic [DWIDTH-1:0] a,
                                                  input logic [DWIDTH-1:0] b,
                                                  input logic              sub);
      logic [DWIDTH:0] a_x;
      logic [DWIDTH:0] b_x;
      logic [DWIDTH:0] r;
      a_x = {a[DWIDTH-1], a};
      b_x = {b[DWIDTH-1], b};
      if (sub) begin
         r = a_x - b_x;
      end else begin
         r = a_x + b_x;
      end
      if (r[DWIDTH] != r[DWIDTH-1]) begin
         if (r[DWIDTH]) begin
            return {1'b1, 1'b1, {(DWIDTH-1){1'b0}}};
         end else begin
            return {1'b1, 1'b0, {(DWIDTH-1){1'b1}}};
         end
      end else begin
         return {1'b0, r[DWIDTH-1:0]};
      end
   endfunction

   logic [DWIDTH-1:0] b_q, b_d;
   logic              s1_valid_q, s1_valid_d;
   logic [LW-1:0]     s1_a_q, s1_a_d;
   logic              s1_op_q, s1_op_d;
   logic [DWIDTH-1:0] s1_b_q, s1_b_d;
   logic              s2_valid_q, s2_valid_d;
   logic [LW-1:0]     out_data_q, out_data_d;
   logic [NUM-1:0]    out_sat_q, out_sat_d;
   logic              sticky_q, sticky_d;
   logic [15:0]       count_q, count_d;

   logic              s2_en_s;
   logic              s1_en_s;
   logic              s1_fire_s;
   logic              s1_move_s;
   logic              xfer_s;
   logic [LW-1:0]     res_s;
   logic [NUM-1:0]    sat_s;
   logic [DWIDTH:0]   lane_r_s;

   // Handshake enables; in_ready is forced high while reset is asserted.
   always_comb begin
      s2_en_s   = !s2_valid_q || out_ready;
      s1_en_s   = !s1_valid_q || s2_en_s;
      s1_fire_s = in_valid && s1_en_s;
      s1_move_s = s1_valid_q && s2_en_s;
      xfer_s    = s2_valid_q && out_ready;
      in_ready  = s1_en_s || !rst;
   end

   // Per-lane saturating arithmetic on the stage-1 contents.
   always_comb begin
      res_s    = '0;
      sat_s    = '0;
      lane_r_s = '0;
      for (int i = 0; i < NUM; i++) begin
         lane_r_s = sat_addsub(s1_a_q[i*DWIDTH +: DWIDTH], s1_b_q, s1_op_q);
         res_s[i*DWIDTH +: DWIDTH] = lane_r_s[DWIDTH-1:0];
         sat_s[i]                  = lane_r_s[DWIDTH];
      end
   end

   // Next-state for B, both pipeline stages and the statistics.
   always_comb begin
      b_d        = b_q;
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_op_d    = s1_op_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;
      sticky_d   = sticky_q;
      count_d    = count_q;

      if (b_load) begin
         b_d = b_in;
      end else begin
         b_d = b_q;
      end

      // The snapshot takes the pre-load B, so a same-cycle load affects the next beat.
      if (s1_en_s) begin
         s1_valid_d = in_valid;
      end else begin
         s1_valid_d = s1_valid_q;
      end
      if (s1_fire_s) begin
         s1_a_d  = a_in;
         s1_op_d = in_op;
         s1_b_d  = b_q;
      end else begin
         s1_a_d  = s1_a_q;
      end

      if (s2_en_s) begin
         s2_valid_d = s1_valid_q;
      end else begin
         s2_valid_d = s2_valid_q;
      end
      if (s1_move_s) begin
         out_data_d = res_s;
         out_sat_d  = sat_s;
      end else begin
         out_data_d = out_data_q;
      end

      if (clear_stats) begin
         count_d  = 16'd0;
         sticky_d = 1'b0;
      end else if (xfer_s) begin
         count_d  = count_q + 16'd1;
         sticky_d = sticky_q | (|out_sat_q);
      end else begin
         count_d  = count_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         b_q        <= '0;
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_op_q    <= 1'b0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         out_data_q <= '0;
         out_sat_q  <= '0;
         sticky_q   <= 1'b0;
         count_q    <= 16'd0;
      end else begin
         b_q        <= b_d;
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_op_q    <= s1_op_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
         sticky_q   <= sticky_d;
         count_q    <= count_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_data   = out_data_q;
   assign out_sat    = out_sat_q;
   assign sticky_sat = sticky_q;
   assign beat_count = count_q;

endmodule

// File: tb/tb_mode2_sub_pipe.sv
// Directed-vector bench for mode2_sub_pipe (NUM=4, DWIDTH=16).
module tb_mode2_sub_pipe;

   logic        clk;
   logic        rst;
   logic        b_load;
   logic [15:0] b_in;
   logic        in_valid;
   logic        in_ready;
   logic        in_op;
   logic [63:0] a_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [3:0]  out_sat;
   logic        sticky_sat;
   logic [15:0] beat_count;
   logic        clear_stats;

   int checks;
   int failures;

   mode2_sub_pipe #(.NUM(4), .DWIDTH(16)) dut (
      .clk(clk), .rst(rst), .b_load(b_load), .b_in(b_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .a_in(a_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .sticky_sat(sticky_sat), .beat_count(beat_count),
      .clear_stats(clear_stats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_b(input logic [15:0] v);
      b_load = 1'b1;
      b_in   = v;
      tick();
      b_load = 1'b0;
   endtask

   function automatic logic [63:0] rep4(input logic [15:0] v);
      return {v, v, v, v};
   endfunction

   // Back-to-back beat k, lane i = k*0x100 + i*0x10 + add
   function automatic logic [63:0] mk_beat(input int k, input int add);
      logic [63:0] r;
      r = 64'd0;
      for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(k*256 + i*16 + add);
      return r;
   endfunction

   task automatic test_reset;
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_during got=%b exp=1", in_ready); end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== 64'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++;
      if (out_sat !== 4'd0 || sticky_sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b/%b exp=0/0", out_sat, sticky_sat); end
      checks++;
      if (beat_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", beat_count); end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic_sub;
      load_b(16'h0100);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = 1'b1;
      a_in      = {16'hFF00, 16'h0000, 16'h0100, 16'h0300};
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency1 out_valid got=%b exp=0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency2 out_valid got=%b exp=1", out_valid); end
      checks++;
      if (out_data !== {16'hFE00, 16'hFF00, 16'h0000, 16'h0200}) begin
         failures++; $display("FAIL basic_data got=%h exp=fe00ff0000000200", out_data);
      end
      checks++;
      if (out_sat !== 4'b0000) begin failures++; $display("FAIL basic_sat got=%b exp=0000", out_sat); end
      tick();
      checks++;
      if (beat_count !== 16'd1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL basic_count got=%0d/%b exp=1/0", beat_count, out_valid);
      end
   endtask

   task automatic test_saturation;
      logic [15:0] tb_b   [4];
      logic        tb_op  [4];
      logic [63:0] tb_a   [4];
      logic [63:0] tb_exp [4];
      logic [3:0]  tb_sat [4];
      tb_b[0] = 16'h8000; tb_op[0] = 1'b1; tb_a[0] = rep4(16'h0001);
      tb_exp[0] = rep4(16'h7FFF); tb_sat[0] = 4'b1111;
      tb_b[1] = 16'h7FFF; tb_op[1] = 1'b0; tb_a[1] = {16'h0001, 16'h0000, 16'hFFFF, 16'h0001};
      tb_exp[1] = {16'h7FFF, 16'h7FFF, 16'h7FFE, 16'h7FFF}; tb_sat[1] = 4'b1001;
      tb_b[2] = 16'h0001; tb_op[2] = 1'b1; tb_a[2] = rep4(16'h8000);
      tb_exp[2] = rep4(16'h8000); tb_sat[2] = 4'b1111;
      tb_b[3] = 16'h0001; tb_op[3] = 1'b0; tb_a[3] = rep4(16'h7FFE);
      tb_exp[3] = rep4(16'h7FFF); tb_sat[3] = 4'b0000;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         load_b(tb_b[k]);
         in_valid = 1'b1;
         in_op    = tb_op[k];
         a_in     = tb_a[k];
         tick();
         in_valid = 1'b0;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== tb_exp[k] || out_sat !== tb_sat[k]) begin
            failures++;
            $display("FAIL sat_case%0d got=%b/%h/%b exp=1/%h/%b", k, out_valid, out_data, out_sat, tb_exp[k], tb_sat[k]);
         end
         tick();
         checks++;
         if (sticky_sat !== 1'b1) begin failures++; $display("FAIL sat_sticky%0d got=%b exp=1", k, sticky_sat); end
      end
      checks++;
      if (beat_count !== 16'd5) begin failures++; $display("FAIL sat_count got=%0d exp=5", beat_count); end
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      checks++;
      if (beat_count !== 16'd0 || sticky_sat !== 1'b0) begin
         failures++; $display("FAIL sat_clear got=%0d/%b exp=0/0", beat_count, sticky_sat);
      end
      // clear_stats coinciding with a saturated transfer must win
      load_b(16'h8000);
      in_valid = 1'b1;
      in_op    = 1'b1;
      a_in     = rep4(16'h0001);
      tick();
      in_valid = 1'b0;
      tick();
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      checks++;
      if (beat_count !== 16'd0 || sticky_sat !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL sat_clear_priority got=%0d/%b/%b exp=0/0/0", beat_count, sticky_sat, out_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic pat [4];
      int sent;
      int rcvd;
      int cyc;
      int occ;
      logic exp_rdy;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      load_b(16'h0001);
      in_op = 1'b0;
      sent = 0; rcvd = 0; cyc = 0;
      while (rcvd < 10 && cyc < 200) begin
         out_ready = pat[cyc % 4];
         in_valid  = (sent < 10);
         a_in      = mk_beat(sent, 0);
         #1;
         occ     = sent - rcvd;
         exp_rdy = (occ < 2) || out_ready;
         checks++;
         if (in_ready !== exp_rdy) begin
            failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (out_data !== mk_beat(rcvd, 1)) begin
               failures++; $display("FAIL b2b_data beat=%0d got=%h exp=%h", rcvd, out_data, mk_beat(rcvd, 1));
            end
            if (out_ready) rcvd++;
         end
         if (in_valid && in_ready) sent++;
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (rcvd !== 10) begin failures++; $display("FAIL b2b_received got=%0d exp=10", rcvd); end
      checks++;
      if (beat_count !== 16'd10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", beat_count); end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || beat_count !== 16'd10) begin
         failures++; $display("FAIL b2b_no_dup got=%b/%0d exp=0/10", out_valid, beat_count);
      end
   endtask

   task automatic test_b_race;
      load_b(16'h0005);
      out_ready = 1'b1;
      in_op     = 1'b1;
      a_in      = rep4(16'h0020);
      in_valid  = 1'b1;
      b_load    = 1'b1;
      b_in      = 16'h0010;
      tick();
      b_load = 1'b0;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== rep4(16'h001B)) begin
         failures++; $display("FAIL b_race_old got=%b/%h exp=1/%h", out_valid, out_data, rep4(16'h001B));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== rep4(16'h0010)) begin
         failures++; $display("FAIL b_race_new got=%b/%h exp=1/%h", out_valid, out_data, rep4(16'h0010));
      end
      tick();
   endtask

   task automatic test_mixed_op;
      logic [15:0] ev;
      load_b(16'h0004);
      out_ready = 1'b1;
      a_in      = rep4(16'h0008);
      for (int k = 0; k < 6; k++) begin
         in_valid = (k < 4);
         in_op    = k[0];
         tick();
         if (k >= 1 && k <= 4) begin
            ev = ((k - 1) % 2 == 0) ? 16'h000C : 16'h0004;
            checks++;
            if (out_valid !== 1'b1 || out_data !== rep4(ev)) begin
               failures++; $display("FAIL mixed_op%0d got=%b/%h exp=1/%h", k - 1, out_valid, out_data, rep4(ev));
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      load_b(16'h0007);
      out_ready = 1'b0;
      in_op     = 1'b0;
      a_in      = rep4(16'h0100);
      in_valid  = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         failures++; $display("FAIL rst_mid_full got=%b/%b exp=1/0", out_valid, in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
      tick();
      rst       = 1'b1;
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || beat_count !== 16'd0 || out_data !== 64'd0) begin
         failures++; $display("FAIL rst_mid_state got=%b/%0d/%h exp=0/0/0", out_valid, beat_count, out_data);
      end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || beat_count !== 16'd0) begin
         failures++; $display("FAIL rst_mid_flush got=%b/%0d exp=0/0", out_valid, beat_count);
      end
      a_in     = rep4(16'h0003);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== rep4(16'h0003) || out_sat !== 4'd0) begin
         failures++; $display("FAIL rst_mid_b_zero got=%b/%h exp=1/%h", out_valid, out_data, rep4(16'h0003));
      end
      tick();
      checks++;
      if (beat_count !== 16'd1) begin failures++; $display("FAIL rst_mid_count got=%0d exp=1", beat_count); end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b0;
      b_load      = 1'b0;
      b_in        = 16'd0;
      in_valid    = 1'b0;
      in_op       = 1'b0;
      a_in        = 64'd0;
      out_ready   = 1'b1;
      clear_stats = 1'b0;
      test_reset();
      test_basic_sub();
      test_saturation();
      test_back_to_back();
      test_b_race();
      test_mixed_op();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
